// File: rtl/data_mem_ctrl_if.sv
// Bus bundle between the CPU load/store stage, the data RAM and data_mem_ctrl.
// slave  : the controller's view. It takes CPU requests and RAM read data, and drives
//          the responses and the RAM control.
// master : the environment's view (CPU plus RAM). It drives requests and RAM read data.
// Signals:
//   req_*  CPU request channel (valid/ready handshake, we, size, sext, byte addr, wdata)
//   rsp_*  completion channel (one-cycle valid, load data, misalignment error)
//   mem_*  single-port 16-bit RAM port (ce, oce, wre, reset, word addr, din, dout)
interface data_mem_ctrl_if #(
  parameter int unsigned ADDR_W = 10
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic              req_size;
  logic              req_sext;
  logic [ADDR_W:0]   req_addr;
  logic [15:0]       req_wdata;

  logic              rsp_valid;
  logic [15:0]       rsp_rdata;
  logic              rsp_err;

  logic              mem_ce;
  logic              mem_oce;
  logic              mem_wre;
  logic              mem_reset;
  logic [ADDR_W-1:0] mem_ad;
  logic [15:0]       mem_din;
  logic [15:0]       mem_dout;

  modport slave (
    input  req_valid, req_we, req_size, req_sext, req_addr, req_wdata, mem_dout,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_ce, mem_oce, mem_wre, mem_reset, mem_ad, mem_din
  );

  modport master (
    output req_valid, req_we, req_size, req_sext, req_addr, req_wdata, mem_dout,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_ce, mem_oce, mem_wre, mem_reset, mem_ad, mem_din
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Load/store initiator for the 16-bit single-port data RAM.
// Serves byte/halfword loads and stores from the CPU; byte stores are a read-modify-write
// because the RAM only writes whole halfwords. Misaligned halfword accesses complete
// immediately with an error and never touch the RAM.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    data_mem_ctrl_if.slave: CPU req/rsp channels and the RAM port
// Parameters:
//   ADDR_W RAM word-address width (CPU byte address is ADDR_W+1 bits)
//   RD_LAT RAM read latency, 1 (bypass) or 2 (output-registered)
module data_mem_ctrl #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned RD_LAT = 1
) (
  input logic             clk,
  input logic             rst_n,
  data_mem_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StRd, StWait, StWr} state_e;

  // WAIT lasts RD_LAT cycles; wait_q marks the last of them when RD_LAT is 2.
  localparam logic WaitLast = (RD_LAT == 2);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic              size_q, size_d;
  logic              sext_q, sext_d;
  logic              lane_q, lane_d;
  logic [7:0]        wbyte_q, wbyte_d;
  logic              wait_q, wait_d;
  logic              mem_ce_q, mem_ce_d;
  logic              mem_wre_q, mem_wre_d;
  logic [ADDR_W-1:0] mem_ad_q, mem_ad_d;
  logic [15:0]       mem_din_q, mem_din_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [15:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic       accept;
  logic       misalign;
  logic [7:0] rd_byte;

  assign accept   = bus.req_valid && (state_q == StIdle);
  assign misalign = bus.req_size && bus.req_addr[0];
  assign rd_byte  = lane_q ? bus.mem_dout[15:8] : bus.mem_dout[7:0];

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    sext_d      = sext_q;
    lane_d      = lane_q;
    wbyte_d     = wbyte_q;
    wait_d      = 1'b0;
    mem_ad_d    = mem_ad_q;
    mem_din_d   = mem_din_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          we_d    = bus.req_we;
          size_d  = bus.req_size;
          sext_d  = bus.req_sext;
          lane_d  = bus.req_addr[0];
          wbyte_d = bus.req_wdata[7:0];
          if (misalign) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            mem_ad_d = bus.req_addr[ADDR_W:1];
            if (bus.req_we && bus.req_size) begin
              mem_din_d = bus.req_wdata;
              state_d   = StWr;
            end else begin
              state_d = StRd;
            end
          end
        end
      end
      StRd: state_d = StWait;
      StWait: begin
        if (wait_q == WaitLast) begin
          if (we_q) begin
            // Byte store: keep the untouched lane from the RAM, replace the other.
            mem_din_d = lane_q ? {wbyte_q, bus.mem_dout[7:0]} : {bus.mem_dout[15:8], wbyte_q};
            state_d   = StWr;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = size_q ? bus.mem_dout : {{8{sext_q & rd_byte[7]}}, rd_byte};
            state_d     = StIdle;
          end
        end else begin
          wait_d = 1'b1;
        end
      end
      StWr: begin
        rsp_valid_d = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // RAM strobes are registered, so they follow the state being entered.
    mem_ce_d  = (state_d == StRd) || (state_d == StWr);
    mem_wre_d = (state_d == StWr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      size_q      <= 1'b0;
      sext_q      <= 1'b0;
      lane_q      <= 1'b0;
      wbyte_q     <= '0;
      wait_q      <= 1'b0;
      mem_ce_q    <= 1'b0;
      mem_wre_q   <= 1'b0;
      mem_ad_q    <= '0;
      mem_din_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      sext_q      <= sext_d;
      lane_q      <= lane_d;
      wbyte_q     <= wbyte_d;
      wait_q      <= wait_d;
      mem_ce_q    <= mem_ce_d;
      mem_wre_q   <= mem_wre_d;
      mem_ad_q    <= mem_ad_d;
      mem_din_q   <= mem_din_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready = (state_q == StIdle);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.mem_ce    = mem_ce_q;
  assign bus.mem_oce   = 1'b1;
  assign bus.mem_wre   = mem_wre_q;
  assign bus.mem_reset = 1'b0;
  assign bus.mem_ad    = mem_ad_q;
  assign bus.mem_din   = mem_din_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: dut0 uses a bypass RAM (RD_LAT=1), dut1 an output-registered
// RAM (RD_LAT=2). Expected responses go into a scoreboard queue at the accept edge and
// are popped when rsp_valid is seen.
module tb_data_mem_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_mem_ctrl_if #(.ADDR_W(10)) if0 ();
  data_mem_ctrl_if #(.ADDR_W(10)) if1 ();

  data_mem_ctrl #(.ADDR_W(10), .RD_LAT(1)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  data_mem_ctrl #(.ADDR_W(10), .RD_LAT(2)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  // RAM models
  logic [15:0] ram0 [1024];
  logic [15:0] ram1 [1024];
  logic [15:0] stage1;

  always @(posedge clk) begin
    if (if0.mem_ce) begin
      if (if0.mem_wre) ram0[if0.mem_ad] <= if0.mem_din;
      else             if0.mem_dout <= ram0[if0.mem_ad];
    end
  end

  always @(posedge clk) begin
    if (if1.mem_ce) begin
      if (if1.mem_wre) ram1[if1.mem_ad] <= if1.mem_din;
      else             stage1 <= ram1[if1.mem_ad];
    end
    if (if1.mem_oce) if1.mem_dout <= stage1;
  end

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  typedef struct {
    logic        we;
    logic        size;
    logic        sext;
    logic [10:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          lat;
  } op_t;

  exp_t sb_q[$];
  int   n_run  = 0;
  int   n_fail = 0;

  // Observations of the last do_req0 call
  logic [15:0] o_rdata;
  logic        o_err;
  int          o_lat;
  int          o_ce;
  int          o_wre;
  logic [9:0]  o_ad;
  logic [15:0] o_din;

  // One request on dut0; pushes its expectation at accept, records what the DUT did.
  task automatic do_req0(input logic we, input logic size, input logic sext,
                         input logic [10:0] addr, input logic [15:0] wdata,
                         input logic [15:0] exp_rdata, input logic exp_err, input int exp_lat);
    int guard;
    exp_t e;
    @(negedge clk);
    if0.req_valid = 1'b1;
    if0.req_we    = we;
    if0.req_size  = size;
    if0.req_sext  = sext;
    if0.req_addr  = addr;
    if0.req_wdata = wdata;
    guard = 0;
    while (!if0.req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.lat   = exp_lat;
    e.acc   = 0;
    sb_q.push_back(e);
    @(negedge clk);
    // Scramble the inputs: the DUT must work from what it captured.
    if0.req_valid = 1'b0;
    if0.req_we    = 1'($urandom);
    if0.req_size  = 1'($urandom);
    if0.req_sext  = 1'($urandom);
    if0.req_addr  = 11'($urandom);
    if0.req_wdata = 16'($urandom);
    o_lat = -1; o_ce = 0; o_wre = 0; o_ad = '0; o_din = '0; o_rdata = '0; o_err = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if (if0.mem_ce) o_ce++;
      if (if0.mem_wre) begin
        o_wre++;
        o_ad  = if0.mem_ad;
        o_din = if0.mem_din;
      end
      if (if0.rsp_valid) begin
        o_lat   = n;
        o_rdata = if0.rsp_rdata;
        o_err   = if0.rsp_err;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    if0.req_valid = 1'b0; if0.req_we = 1'b0; if0.req_size = 1'b0; if0.req_sext = 1'b0;
    if0.req_addr = '0; if0.req_wdata = '0;
    if1.req_valid = 1'b0; if1.req_we = 1'b0; if1.req_size = 1'b0; if1.req_sext = 1'b0;
    if1.req_addr = '0; if1.req_wdata = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_run++;
    if ({if0.req_ready, if0.mem_ce, if0.mem_wre, if0.mem_ad, if0.mem_din, if0.rsp_valid,
         if0.rsp_rdata, if0.rsp_err} !== {1'b1, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b0,
         16'h0000, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_dut0: got rdy=%b ce=%b wre=%b ad=%h din=%h rv=%b rd=%h err=%b",
               if0.req_ready, if0.mem_ce, if0.mem_wre, if0.mem_ad, if0.mem_din,
               if0.rsp_valid, if0.rsp_rdata, if0.rsp_err);
    end
    n_run++;
    if ({if1.req_ready, if1.mem_ce, if1.mem_wre, if1.rsp_valid, if1.mem_oce, if1.mem_reset}
        !== 6'b100010) begin
      n_fail++;
      $display("FAIL reset_dut1: got rdy=%b ce=%b wre=%b rv=%b oce=%b mreset=%b want 1 0 0 0 1 0",
               if1.req_ready, if1.mem_ce, if1.mem_wre, if1.rsp_valid, if1.mem_oce,
               if1.mem_reset);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_run++;
    if ({if0.req_ready, if0.mem_ce, if0.rsp_valid} !== 3'b100) begin
      n_fail++;
      $display("FAIL idle_after_reset: got rdy=%b ce=%b rv=%b want 1 0 0",
               if0.req_ready, if0.mem_ce, if0.rsp_valid);
    end
  endtask

  task automatic test_hw_store();
    exp_t e;
    do_req0(1'b1, 1'b1, 1'b0, 11'h004, 16'hBEEF, 16'h0000, 1'b0, 2);
    e = sb_q.pop_front();
    n_run++;
    if (o_rdata !== e.rdata || o_err !== e.err || o_lat != e.lat) begin
      n_fail++;
      $display("FAIL hw_store rsp: got rd=%h err=%b lat=%0d want rd=%h err=%b lat=%0d",
               o_rdata, o_err, o_lat, e.rdata, e.err, e.lat);
    end
    n_run++;
    if (o_ce != 1 || o_wre != 1 || o_ad !== 10'd2 || o_din !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL hw_store ram: got ce=%0d wre=%0d ad=%h din=%h want 1 1 002 beef",
               o_ce, o_wre, o_ad, o_din);
    end
    // Second word for the upper-lane byte store below.
    do_req0(1'b1, 1'b1, 1'b0, 11'h006, 16'h5678, 16'h0000, 1'b0, 2);
    e = sb_q.pop_front();
    n_run++;
    if (o_rdata !== e.rdata || o_err !== e.err || o_lat != e.lat || o_din !== 16'h5678) begin
      n_fail++;
      $display("FAIL hw_store2: got rd=%h err=%b lat=%0d din=%h want rd=%h err=%b lat=%0d din=5678",
               o_rdata, o_err, o_lat, o_din, e.rdata, e.err, e.lat);
    end
  endtask

  task automatic test_load();
    exp_t e;
    logic [10:0] addr [4] = '{11'h004, 11'h005, 11'h005, 11'h004};
    logic        size [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic        sext [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] want [4] = '{16'hBEEF, 16'hFFBE, 16'h00BE, 16'hFFEF};
    for (int i = 0; i < 4; i++) begin
      do_req0(1'b0, size[i], sext[i], addr[i], 16'hFFFF, want[i], 1'b0, 3);
      e = sb_q.pop_front();
      n_run++;
      if (o_rdata !== e.rdata || o_err !== e.err || o_lat != e.lat || o_ce != 1 || o_wre != 0)
      begin
        n_fail++;
        $display("FAIL load_%0d: got rd=%h err=%b lat=%0d ce=%0d wre=%0d want rd=%h err=%b lat=%0d ce=1 wre=0",
                 i, o_rdata, o_err, o_lat, o_ce, o_wre, e.rdata, e.err, e.lat);
      end
    end
  endtask

  task automatic test_byte_store();
    exp_t e;
    // rsp_rdata keeps the last load result (0xFFEF) through stores.
    do_req0(1'b1, 1'b0, 1'b0, 11'h004, 16'hAB12, 16'hFFEF, 1'b0, 4);
    e = sb_q.pop_front();
    n_run++;
    if (o_rdata !== e.rdata || o_err !== e.err || o_lat != e.lat) begin
      n_fail++;
      $display("FAIL byte_store_lo rsp: got rd=%h err=%b lat=%0d want rd=%h err=%b lat=%0d",
               o_rdata, o_err, o_lat, e.rdata, e.err, e.lat);
    end
    n_run++;
    if (o_ce != 2 || o_wre != 1 || o_ad !== 10'd2 || o_din !== 16'hBE12) begin
      n_fail++;
      $display("FAIL byte_store_lo ram: got ce=%0d wre=%0d ad=%h din=%h want 2 1 002 be12",
               o_ce, o_wre, o_ad, o_din);
    end
    do_req0(1'b1, 1'b0, 1'b0, 11'h007, 16'h009A, 16'hFFEF, 1'b0, 4);
    e = sb_q.pop_front();
    n_run++;
    if (o_rdata !== e.rdata || o_lat != e.lat || o_ad !== 10'd3 || o_din !== 16'h9A78) begin
      n_fail++;
      $display("FAIL byte_store_hi: got rd=%h lat=%0d ad=%h din=%h want rd=%h lat=%0d ad=003 din=9a78",
               o_rdata, o_lat, o_ad, o_din, e.rdata, e.lat);
    end
    do_req0(1'b0, 1'b1, 1'b0, 11'h004, 16'h0000, 16'hBE12, 1'b0, 3);
    e = sb_q.pop_front();
    n_run++;
    if (o_rdata !== e.rdata || o_err !== e.err || o_lat != e.lat) begin
      n_fail++;
      $display("FAIL load_after_bs: got rd=%h err=%b lat=%0d want rd=%h err=%b lat=%0d",
               o_rdata, o_err, o_lat, e.rdata, e.err, e.lat);
    end
  endtask

  task automatic test_misaligned();
    exp_t e;
    do_req0(1'b0, 1'b1, 1'b0, 11'h003, 16'h0000, 16'hBE12, 1'b1, 1);
    e = sb_q.pop_front();
    n_run++;
    if (o_rdata !== e.rdata || o_err !== e.err || o_lat != e.lat || o_ce != 0) begin
      n_fail++;
      $display("FAIL misaligned_load: got rd=%h err=%b lat=%0d ce=%0d want rd=%h err=%b lat=%0d ce=0",
               o_rdata, o_err, o_lat, o_ce, e.rdata, e.err, e.lat);
    end
    do_req0(1'b1, 1'b1, 1'b0, 11'h005, 16'h1234, 16'hBE12, 1'b1, 1);
    e = sb_q.pop_front();
    n_run++;
    if (o_err !== e.err || o_lat != e.lat || o_ce != 0 || o_wre != 0) begin
      n_fail++;
      $display("FAIL misaligned_store: got err=%b lat=%0d ce=%0d wre=%0d want err=%b lat=%0d ce=0 wre=0",
               o_err, o_lat, o_ce, o_wre, e.err, e.lat);
    end
    do_req0(1'b0, 1'b1, 1'b0, 11'h006, 16'h0000, 16'h9A78, 1'b0, 3);
    e = sb_q.pop_front();
    n_run++;
    if (o_rdata !== e.rdata || o_err !== e.err || o_lat != e.lat) begin
      n_fail++;
      $display("FAIL load_after_err: got rd=%h err=%b lat=%0d want rd=%h err=%b lat=%0d",
               o_rdata, o_err, o_lat, e.rdata, e.err, e.lat);
    end
  endtask

  task automatic test_reset_mid_rmw();
    exp_t e;
    int   wre_seen;
    @(negedge clk);
    if0.req_valid = 1'b1; if0.req_we = 1'b1; if0.req_size = 1'b0; if0.req_sext = 1'b0;
    if0.req_addr = 11'h004; if0.req_wdata = 16'h0055;
    @(posedge clk);
    @(negedge clk);
    if0.req_valid = 1'b0;
    n_run++;
    if (if0.mem_ce !== 1'b1 || if0.mem_wre !== 1'b0) begin
      n_fail++;
      $display("FAIL rmw_rd_cycle: got ce=%b wre=%b want 1 0", if0.mem_ce, if0.mem_wre);
    end
    rst_n = 1'b0;
    wre_seen = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (if0.mem_wre) wre_seen++;
      @(negedge clk);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (if0.mem_wre) wre_seen++;
      @(negedge clk);
    end
    n_run++;
    if (wre_seen != 0 || if0.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_rmw: got wre_cycles=%0d rdy=%b want 0 1", wre_seen, if0.req_ready);
    end
    do_req0(1'b0, 1'b1, 1'b0, 11'h004, 16'h0000, 16'hBE12, 1'b0, 3);
    e = sb_q.pop_front();
    n_run++;
    if (o_rdata !== e.rdata || o_err !== e.err || o_lat != e.lat) begin
      n_fail++;
      $display("FAIL word_unchanged: got rd=%h err=%b lat=%0d want rd=%h err=%b lat=%0d",
               o_rdata, o_err, o_lat, e.rdata, e.err, e.lat);
    end
  endtask

  task automatic test_back_to_back();
    op_t  ops [10];
    exp_t e;
    int   idx, k, done, last_k;
    logic rdy;
    ops[0] = '{1'b1, 1'b1, 1'b0, 11'h010, 16'h1111, 16'h0000, 2};
    ops[1] = '{1'b1, 1'b1, 1'b0, 11'h012, 16'hA5C3, 16'h0000, 2};
    ops[2] = '{1'b1, 1'b1, 1'b0, 11'h014, 16'h7E80, 16'h0000, 2};
    ops[3] = '{1'b0, 1'b1, 1'b0, 11'h010, 16'h0000, 16'h1111, 4};
    ops[4] = '{1'b0, 1'b1, 1'b0, 11'h012, 16'h0000, 16'hA5C3, 4};
    ops[5] = '{1'b0, 1'b0, 1'b1, 11'h015, 16'h0000, 16'h007E, 4};
    ops[6] = '{1'b0, 1'b0, 1'b1, 11'h014, 16'h0000, 16'hFF80, 4};
    ops[7] = '{1'b0, 1'b1, 1'b0, 11'h014, 16'h0000, 16'h7E80, 4};
    ops[8] = '{1'b1, 1'b0, 1'b0, 11'h013, 16'h0011, 16'h7E80, 5};
    ops[9] = '{1'b0, 1'b1, 1'b0, 11'h012, 16'h0000, 16'h11C3, 4};
    idx = 0; k = 0; done = 0; last_k = -1;
    @(negedge clk);
    while (done < 10 && k < 200) begin
      if (if1.rsp_valid) begin
        n_run++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_spurious: got rsp_valid at cycle %0d want no response", k);
        end else begin
          e = sb_q.pop_front();
          if (if1.rsp_rdata !== e.rdata || if1.rsp_err !== e.err || k - e.acc != e.lat) begin
            n_fail++;
            $display("FAIL b2b_rsp_%0d: got rd=%h err=%b lat=%0d want rd=%h err=%b lat=%0d",
                     done, if1.rsp_rdata, if1.rsp_err, k - e.acc, e.rdata, e.err, e.lat);
          end
        end
        done++;
        last_k = k;
      end
      if (idx < 10) begin
        if1.req_valid = 1'b1;
        if1.req_we    = ops[idx].we;
        if1.req_size  = ops[idx].size;
        if1.req_sext  = ops[idx].sext;
        if1.req_addr  = ops[idx].addr;
        if1.req_wdata = ops[idx].wdata;
      end else begin
        if1.req_valid = 1'b0;
      end
      rdy = if1.req_ready;
      @(posedge clk);
      if (idx < 10 && rdy) begin
        e.rdata = ops[idx].rdata;
        e.err   = 1'b0;
        e.lat   = ops[idx].lat;
        e.acc   = k;
        sb_q.push_back(e);
        idx++;
      end
      @(negedge clk);
      k++;
    end
    if1.req_valid = 1'b0;
    // Each accept lands on the previous completion, so the last response closes the sum.
    n_run++;
    if (done != 10 || last_k != 35) begin
      n_fail++;
      $display("FAIL b2b_throughput: got %0d responses, last at cycle %0d want 10 at 35",
               done, last_k);
    end
  endtask

  initial begin
    test_reset();
    test_hw_store();
    test_load();
    test_byte_store();
    test_misaligned();
    test_reset_mid_rmw();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
